// File: rtl/nec_ir_pkg.sv
// nec_ir_pkg: state encoding, timing windows and frame layout for the NEC IR
// receiver. The ST_REP_MARK state exists only when NEC_IR_REPEAT_EN is defined.
package nec_ir_pkg;

`ifdef NEC_IR_REPEAT_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_LEAD_MARK, ST_LEAD_SPACE, ST_BIT_MARK, ST_BIT_SPACE, ST_REP_MARK
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_LEAD_MARK, ST_LEAD_SPACE, ST_BIT_MARK, ST_BIT_SPACE
   } state_t;
`endif

   localparam int TICK_W     = 9;
   localparam int TICK_MAX   = 511;
   localparam int FRAME_BITS = 32;

   // Exclusive window bounds in microseconds; converted to ticks per TICK_US.
   localparam int LEAD_MARK_LO_US  = 7595;
   localparam int LEAD_MARK_HI_US  = 10395;
   localparam int LEAD_SPACE_LO_US = 3080;
   localparam int LEAD_SPACE_HI_US = 5880;
   localparam int REP_SPACE_LO_US  = 1750;
   localparam int REP_SPACE_HI_US  = 2800;
   localparam int BIT_MARK_LO_US   = 210;
   localparam int BIT_MARK_HI_US   = 910;
   localparam int ZERO_SPACE_LO_US = 210;
   localparam int ZERO_SPACE_HI_US = 910;
   localparam int ONE_SPACE_LO_US  = 1330;
   localparam int ONE_SPACE_HI_US  = 2030;

   // Byte positions inside the 32-bit frame (received LSB first).
   localparam int ADDR_POS  = 0;
   localparam int ADDRN_POS = 8;
   localparam int CMD_POS   = 16;
   localparam int CMDN_POS  = 24;

   function automatic logic [TICK_W-1:0] us_to_ticks(input int us, input int tick_us);
      int t;
      t = us / tick_us;
      if (t > TICK_MAX) t = TICK_MAX;
      return t[TICK_W-1:0];
   endfunction

   function automatic logic in_window(input logic [TICK_W-1:0] t,
                                      input logic [TICK_W-1:0] lo,
                                      input logic [TICK_W-1:0] hi);
      return (t > lo) && (t < hi);
   endfunction

endpackage

// File: rtl/ir_sync_edge.sv
// ir_sync_edge: brings the raw IR line into the clock domain and reports the
// start and end of each mark, independent of the receiver's output polarity.
module ir_sync_edge #(
   parameter int IR_ACTIVE_LOW = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_ir,
   output logic o_mark_start,
   output logic o_mark_end
);
   // Level the line rests at between bursts.
   localparam logic IDLE_LVL = (IR_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic r_meta, r_sync, r_hist;
   logic w_mark_now, w_mark_prev;

   // Two synchroniser flops plus one history flop; reset to the idle level so
   // release from reset never looks like an edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= IDLE_LVL;
         r_sync <= IDLE_LVL;
         r_hist <= IDLE_LVL;
      end else begin
         r_meta <= i_ir;
         r_sync <= r_meta;
         r_hist <= r_sync;
      end
   end

   assign w_mark_now   = r_sync ^ IDLE_LVL;
   assign w_mark_prev  = r_hist ^ IDLE_LVL;
   assign o_mark_start = w_mark_now & ~w_mark_prev;
   assign o_mark_end   = ~w_mark_now & w_mark_prev;
endmodule

// File: rtl/nec_ir_rx.sv
// nec_ir_rx: NEC infrared frame decoder with valid/ready output handshake.
// Define NEC_IR_REPEAT_EN to decode repeat codes (replays the last frame).
// The repeat flag output is named is_repeat because "repeat" is a keyword.
module nec_ir_rx
   import nec_ir_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int TICK_US       = 35,
   parameter int IR_ACTIVE_LOW = 1,
   parameter int TIMEOUT_TICKS = 320
) (
   input  logic       FPGA_CLK,
   input  logic       FPGA_RST,
   input  logic       IR,
   output logic       frame_valid,
   input  logic       frame_ready,
   output logic [7:0] addr,
   output logic [7:0] addr_n,
   output logic [7:0] cmd,
   output logic       is_repeat,
   output logic       err,
   output logic       ovr
);
   // Multiply before dividing: identical for whole-MHz clocks, and still
   // usable for slow clocks; never below one cycle per tick.
   localparam longint DIV_RAW   = (longint'(CLK_HZ) * longint'(TICK_US)) / 1_000_000;
   localparam int     PRESC_DIV = (DIV_RAW < 1) ? 1 : int'(DIV_RAW);
   localparam int     PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

   localparam logic [TICK_W-1:0] TICK_SAT = '1;
   localparam logic [TICK_W-1:0] TO_TICKS = TICK_W'(TIMEOUT_TICKS);
   localparam logic [TICK_W-1:0] LM_LO = us_to_ticks(LEAD_MARK_LO_US,  TICK_US);
   localparam logic [TICK_W-1:0] LM_HI = us_to_ticks(LEAD_MARK_HI_US,  TICK_US);
   localparam logic [TICK_W-1:0] LS_LO = us_to_ticks(LEAD_SPACE_LO_US, TICK_US);
   localparam logic [TICK_W-1:0] LS_HI = us_to_ticks(LEAD_SPACE_HI_US, TICK_US);
   localparam logic [TICK_W-1:0] BM_LO = us_to_ticks(BIT_MARK_LO_US,   TICK_US);
   localparam logic [TICK_W-1:0] BM_HI = us_to_ticks(BIT_MARK_HI_US,   TICK_US);
   localparam logic [TICK_W-1:0] B0_LO = us_to_ticks(ZERO_SPACE_LO_US, TICK_US);
   localparam logic [TICK_W-1:0] B0_HI = us_to_ticks(ZERO_SPACE_HI_US, TICK_US);
   localparam logic [TICK_W-1:0] B1_LO = us_to_ticks(ONE_SPACE_LO_US,  TICK_US);
   localparam logic [TICK_W-1:0] B1_HI = us_to_ticks(ONE_SPACE_HI_US,  TICK_US);
`ifdef NEC_IR_REPEAT_EN
   localparam logic [TICK_W-1:0] RS_LO = us_to_ticks(REP_SPACE_LO_US,  TICK_US);
   localparam logic [TICK_W-1:0] RS_HI = us_to_ticks(REP_SPACE_HI_US,  TICK_US);
`endif

   logic                  w_mark_start, w_mark_end, w_edge;
   logic [PRESC_W-1:0]    r_presc;
   logic [TICK_W-1:0]     r_ticks;
   state_t                r_state, w_nxt_state;
   logic [5:0]            r_cnt, w_nxt_cnt;
   logic [FRAME_BITS-1:0] r_shift, w_nxt_shift;
   logic                  w_abort, w_done, w_done_rep, w_cmd_ok, w_hs;
   logic [7:0]            w_ld_addr, w_ld_addr_n, w_ld_cmd;
   logic                  r_valid, r_err, r_ovr;
   logic [7:0]            r_addr, r_addr_n, r_cmd;
`ifdef NEC_IR_REPEAT_EN
   logic                  r_rep, r_have_last;
   logic [7:0]            r_last_addr, r_last_addr_n, r_last_cmd;
`endif

   ir_sync_edge #(.IR_ACTIVE_LOW(IR_ACTIVE_LOW)) u_sync (
      .i_clk        (FPGA_CLK),
      .i_rst_n      (FPGA_RST),
      .i_ir         (IR),
      .o_mark_start (w_mark_start),
      .o_mark_end   (w_mark_end)
   );

   assign w_edge   = w_mark_start | w_mark_end;
   assign w_cmd_ok = (r_shift[CMDN_POS +: 8] == ~r_shift[CMD_POS +: 8]);
   assign w_hs     = r_valid & frame_ready;

   // Duration measurement: prescaler and tick counter restart on every edge,
   // ticks saturate so long idle periods never wrap into a valid window.
   always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
      if (!FPGA_RST) begin
         r_presc <= '0;
         r_ticks <= '0;
      end else if (w_edge) begin
         r_presc <= '0;
         r_ticks <= '0;
      end else if (r_presc == PRESC_LAST) begin
         r_presc <= '0;
         if (r_ticks != TICK_SAT) r_ticks <= r_ticks + 1'b1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // Decoder state, bit counter and shift register.
   always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
      if (!FPGA_RST) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_shift <= w_nxt_shift;
      end
   end

   // Next state: each edge closes the phase just measured in r_ticks.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_shift = r_shift;
      w_abort     = 1'b0;
      w_done      = 1'b0;
      w_done_rep  = 1'b0;
      case (r_state)
         ST_IDLE: if (w_mark_start) w_nxt_state = ST_LEAD_MARK;
         ST_LEAD_MARK: if (w_mark_end) begin
            if (in_window(r_ticks, LM_LO, LM_HI)) w_nxt_state = ST_LEAD_SPACE;
            else begin w_nxt_state = ST_IDLE; w_abort = 1'b1; end
         end
         ST_LEAD_SPACE: if (w_mark_start) begin
            if (in_window(r_ticks, LS_LO, LS_HI)) begin
               w_nxt_state = ST_BIT_MARK;
               w_nxt_cnt   = '0;
               w_nxt_shift = '0;
            end
`ifdef NEC_IR_REPEAT_EN
            else if (in_window(r_ticks, RS_LO, RS_HI)) w_nxt_state = ST_REP_MARK;
`endif
            else begin w_nxt_state = ST_IDLE; w_abort = 1'b1; end
         end
         ST_BIT_MARK: if (w_mark_end) begin
            if (!in_window(r_ticks, BM_LO, BM_HI)) begin
               w_nxt_state = ST_IDLE; w_abort = 1'b1;
            end else if (r_cnt < 6'd32) begin
               w_nxt_state = ST_BIT_SPACE;
            end else begin
               // Stop-bit mark: frame complete, command byte must self-check.
               w_nxt_state = ST_IDLE;
               if (w_cmd_ok) w_done = 1'b1;
               else          w_abort = 1'b1;
            end
         end
         ST_BIT_SPACE: if (w_mark_start) begin
            if (in_window(r_ticks, B0_LO, B0_HI)) begin
               w_nxt_shift = {1'b0, r_shift[FRAME_BITS-1:1]};
               w_nxt_cnt   = r_cnt + 6'd1;
               w_nxt_state = ST_BIT_MARK;
            end else if (in_window(r_ticks, B1_LO, B1_HI)) begin
               w_nxt_shift = {1'b1, r_shift[FRAME_BITS-1:1]};
               w_nxt_cnt   = r_cnt + 6'd1;
               w_nxt_state = ST_BIT_MARK;
            end else begin
               w_nxt_state = ST_IDLE; w_abort = 1'b1;
            end
         end
`ifdef NEC_IR_REPEAT_EN
         ST_REP_MARK: if (w_mark_end) begin
            w_nxt_state = ST_IDLE;
            if (in_window(r_ticks, BM_LO, BM_HI) && r_have_last) w_done_rep = 1'b1;
            else                                                  w_abort    = 1'b1;
         end
`endif
         default: w_nxt_state = ST_IDLE;
      endcase
      // Line stuck mid-frame: give up once no edge has arrived for too long.
      if (r_state != ST_IDLE && !w_edge && r_ticks >= TO_TICKS) begin
         w_nxt_state = ST_IDLE;
         w_abort     = 1'b1;
      end
   end

`ifdef NEC_IR_REPEAT_EN
   assign w_ld_addr   = w_done_rep ? r_last_addr   : r_shift[ADDR_POS  +: 8];
   assign w_ld_addr_n = w_done_rep ? r_last_addr_n : r_shift[ADDRN_POS +: 8];
   assign w_ld_cmd    = w_done_rep ? r_last_cmd    : r_shift[CMD_POS   +: 8];

   // Remember the last good full frame so repeat codes can replay it.
   always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
      if (!FPGA_RST) begin
         r_have_last   <= 1'b0;
         r_last_addr   <= '0;
         r_last_addr_n <= '0;
         r_last_cmd    <= '0;
      end else if (w_done) begin
         r_have_last   <= 1'b1;
         r_last_addr   <= r_shift[ADDR_POS  +: 8];
         r_last_addr_n <= r_shift[ADDRN_POS +: 8];
         r_last_cmd    <= r_shift[CMD_POS   +: 8];
      end
   end
`else
   assign w_ld_addr   = r_shift[ADDR_POS  +: 8];
   assign w_ld_addr_n = r_shift[ADDRN_POS +: 8];
   assign w_ld_cmd    = r_shift[CMD_POS   +: 8];
`endif

   // Output holding registers: a completed frame loads only if the slot is
   // free or being accepted this cycle; otherwise it is dropped with ovr.
   always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
      if (!FPGA_RST) begin
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_ovr    <= 1'b0;
         r_addr   <= '0;
         r_addr_n <= '0;
         r_cmd    <= '0;
`ifdef NEC_IR_REPEAT_EN
         r_rep    <= 1'b0;
`endif
      end else begin
         r_err <= w_abort;
         r_ovr <= 1'b0;
         if (w_hs) r_valid <= 1'b0;
         if (w_done | w_done_rep) begin
            if (!r_valid || w_hs) begin
               r_valid  <= 1'b1;
               r_addr   <= w_ld_addr;
               r_addr_n <= w_ld_addr_n;
               r_cmd    <= w_ld_cmd;
`ifdef NEC_IR_REPEAT_EN
               r_rep    <= w_done_rep;
`endif
            end else begin
               r_ovr <= 1'b1;
            end
         end
      end
   end

   assign frame_valid = r_valid;
   assign addr        = r_addr;
   assign addr_n      = r_addr_n;
   assign cmd         = r_cmd;
   assign err         = r_err;
   assign ovr         = r_ovr;
`ifdef NEC_IR_REPEAT_EN
   assign is_repeat   = r_rep;
`else
   assign is_repeat   = 1'b0;
`endif
endmodule
